// File: rtl/chunked_negate_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : chunked_negate_unit_pkg                                    |
// | Description : Mode codes, FSM encodings and helpers for the chunked      |
// |               negate unit.                                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package chunked_negate_unit_pkg;

    localparam logic [1:0] NEG_MODE_PASS = 2'b00;
    localparam logic [1:0] NEG_MODE_NEG  = 2'b01;
    localparam logic [1:0] NEG_MODE_ABS  = 2'b10;
    localparam logic [1:0] NEG_MODE_SMAG = 2'b11;

    localparam int              ST_W    = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // Abs and sign-magnitude only invert negative operands.
    function automatic logic neg_invert(input logic [1:0] mode, input logic msb);
        return (mode == NEG_MODE_NEG) ||
               (((mode == NEG_MODE_ABS) || (mode == NEG_MODE_SMAG)) && msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunked_negate_unit_adder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : chunked_negate_unit_adder                                  |
// | Description : Narrow unsigned adder with carry-out on overflow.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module chunked_negate_unit_adder #(
    parameter int ADDER_SIZE = 8
) (
    input  logic [ADDER_SIZE-1:0] dIn0,
    input  logic [ADDER_SIZE-1:0] dIn1,
    output logic [ADDER_SIZE-1:0] dOut,
    output logic                  overflow
);

    assign {overflow, dOut} = {1'b0, dIn0} + {1'b0, dIn1};

endmodule
`default_nettype wire

// File: rtl/chunked_negate_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : chunked_negate_unit                                        |
// | Description : Pass / negate / abs / sign-magnitude of a word, computed   |
// |               CHUNK_SIZE bits per cycle, LSB first, with handshakes.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module chunked_negate_unit #(
    parameter int NUM_SIZE   = 32,
    parameter int CHUNK_SIZE = 8
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [1:0]          mode,
    input  logic [NUM_SIZE-1:0] dIn,
    output logic                outValid,
    input  logic                outReady,
    output logic [NUM_SIZE-1:0] dOut,
    output logic                ovf
);
    import chunked_negate_unit_pkg::*;

    localparam int                NUM_CHUNKS = NUM_SIZE / CHUNK_SIZE;
    localparam int                CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int                IDX_W      = $clog2(NUM_SIZE) + 1;
    localparam logic [CNT_W-1:0]  LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [NUM_SIZE-1:0] MOST_NEG = {1'b1, {(NUM_SIZE-1){1'b0}}};

    logic [ST_W-1:0]       state_q, state_d;
    logic [NUM_SIZE-1:0]   data_q;
    logic [NUM_SIZE-1:0]   dout_q, dout_d;
    logic [1:0]            mode_q;
    logic                  inv_q;
    logic                  carry_q;
    logic                  ovf_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  w_accept;
    logic                  w_release;
    logic                  w_last;
    logic                  w_inv;
    logic [IDX_W-1:0]      w_base;
    logic [CHUNK_SIZE-1:0] w_slice;
    logic [CHUNK_SIZE-1:0] w_carry_vec;
    logic [CHUNK_SIZE-1:0] w_sum;
    logic [CHUNK_SIZE-1:0] w_res;
    logic                  w_cout;

    assign w_accept  = inValid  && (state_q == ST_IDLE);
    assign w_release = outReady && (state_q == ST_DONE);
    assign w_last    = (cnt_q == LAST_CHUNK);
    assign w_inv     = neg_invert(mode, dIn[NUM_SIZE-1]);

    // Two's-complement negation as ~x + 1, rippled one chunk at a time.
    assign w_base      = IDX_W'(cnt_q) * IDX_W'(CHUNK_SIZE);
    assign w_slice     = inv_q ? ~data_q[w_base +: CHUNK_SIZE] : data_q[w_base +: CHUNK_SIZE];
    assign w_carry_vec = CHUNK_SIZE'(carry_q);

    chunked_negate_unit_adder #(
        .ADDER_SIZE (CHUNK_SIZE)
    ) u_adder (
        .dIn0     (w_slice),
        .dIn1     (w_carry_vec),
        .dOut     (w_sum),
        .overflow (w_cout)
    );

    // Sign-magnitude keeps the operand's sign bit on top of the magnitude.
    always_comb begin
        w_res = w_sum;
        if ((mode_q == NEG_MODE_SMAG) && w_last) begin
            w_res[CHUNK_SIZE-1] = data_q[NUM_SIZE-1];
        end
    end

    always_comb begin
        dout_d                        = dout_q;
        dout_d[w_base +: CHUNK_SIZE]  = w_res;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (inValid)  state_d = ST_RUN;
            ST_RUN:  if (w_last)   state_d = ST_DONE;
            ST_DONE: if (outReady) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady  = (state_q == ST_IDLE);
        outValid = (state_q == ST_DONE);
        dOut     = dout_q;
        ovf      = ovf_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_q  <= '0;
            dout_q  <= '0;
            mode_q  <= NEG_MODE_PASS;
            inv_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (w_accept) begin
            data_q  <= dIn;
            dout_q  <= '0;
            mode_q  <= mode;
            inv_q   <= w_inv;
            carry_q <= w_inv;
            ovf_q   <= w_inv && (dIn == MOST_NEG);
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            dout_q  <= dout_d;
            carry_q <= w_cout;
            cnt_q   <= w_last ? '0 : cnt_q + 1'b1;
        end else if (w_release) begin
            ovf_q   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chunked_negate_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_chunked_negate_unit                                     |
// | Description : Self-checking bench: arithmetic model plus literal vectors.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_chunked_negate_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid, inReady, outValid, outReady, ovf;
    logic [1:0]  mode;
    logic [31:0] dIn, dOut;

    logic        v16, r16, ov16, or16, ovf16;
    logic [1:0]  m16;
    logic [15:0] d16, q16;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_cyc = 0;
    int          n_done  = 0;
    bit          seen_valid = 1'b0;
    bit          rand_bp    = 1'b0;
    logic [32:0] expq[$];

    always #5 clk = ~clk;

    chunked_negate_unit #(.NUM_SIZE(32), .CHUNK_SIZE(8)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .mode(mode),
        .dIn(dIn), .outValid(outValid), .outReady(outReady), .dOut(dOut), .ovf(ovf)
    );

    chunked_negate_unit #(.NUM_SIZE(16), .CHUNK_SIZE(16)) dut16 (
        .clk(clk), .rstN(rstN), .inValid(v16), .inReady(r16), .mode(m16),
        .dIn(d16), .outValid(ov16), .outReady(or16), .dOut(q16), .ovf(ovf16)
    );

    // Reference: {ovf, result} straight from the arithmetic definition.
    function automatic logic [32:0] model(input logic [1:0] m, input logic [31:0] d);
        logic [31:0] mag, r;
        logic        o;
        mag = d[31] ? (32'd0 - d) : d;
        case (m)
            2'b00:   r = d;
            2'b01:   r = 32'd0 - d;
            2'b10:   r = mag;
            default: r = {d[31], mag[30:0]};
        endcase
        o = (m != 2'b00) && (d == 32'h8000_0000);
        return {o, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rstN === 1'b1) begin
            if (inValid && inReady) begin
                expq.push_back(model(mode, dIn));
                acc_cyc    = cyc;
                seen_valid = 1'b0;
            end
            if (outValid && outReady) begin
                if (expq.size() > 0) void'(expq.pop_front());
                n_done++;
            end
        end
    end

    always @(negedge rstN) expq.delete();

    always @(negedge clk) begin
        if ((rstN === 1'b1) && (outValid === 1'b1)) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got outValid=1 want no pending op");
            end else begin
                chk("model_dout", dOut, expq[0][31:0]);
                chk("model_ovf", {31'b0, ovf}, {31'b0, expq[0][32]});
                if (!seen_valid) begin
                    chk("latency", 32'(cyc - acc_cyc), 32'd4);
                    seen_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) if (rand_bp) outReady = 1'($urandom_range(0, 1));

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic issue(input logic [1:0] m, input logic [31:0] d);
        int k = 0;
        while (!inReady && k < 50) begin @(negedge clk); k++; end
        if (!inReady) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got inReady=%b want 1", inReady);
        end
        inValid = 1'b1; mode = m; dIn = d;
        @(negedge clk);
        inValid = 1'b0; mode = 2'($urandom); dIn = $urandom;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!outValid && k < 50) begin @(negedge clk); k++; end
        if (!outValid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got outValid=%b want 1", outValid);
        end
    endtask

    task automatic run_lit(input string nm, input logic [1:0] m, input logic [31:0] d,
                           input logic [31:0] exp, input logic eo);
        issue(m, d);
        wait_valid();
        chk(nm, dOut, exp);
        chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        @(negedge clk);
    endtask

    initial begin
        int n0;
        int k;
        logic [1:0]  m;
        logic [31:0] d;
        rstN = 1'b0; inValid = 1'b0; outReady = 1'b1; mode = 2'b00; dIn = '0;
        v16 = 1'b0; or16 = 1'b1; m16 = 2'b00; d16 = '0;
        #1;
        chk("rst_inReady", {31'b0, inReady}, 32'd1);
        chk("rst_outValid", {31'b0, outValid}, 32'd0);
        chk("rst_dOut", dOut, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst16_dOut", {16'b0, q16}, 32'd0);
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        run_lit("neg_1",       2'b01, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        run_lit("abs_m256",    2'b10, 32'hFFFF_FF00, 32'h0000_0100, 1'b0);
        run_lit("abs_5",       2'b10, 32'h0000_0005, 32'h0000_0005, 1'b0);
        run_lit("neg_0x100",   2'b01, 32'h0000_0100, 32'hFFFF_FF00, 1'b0);
        run_lit("pass",        2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0);
        run_lit("pass_min",    2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_lit("smag_m5",     2'b11, 32'hFFFF_FFFB, 32'h8000_0005, 1'b0);
        run_lit("smag_5",      2'b11, 32'h0000_0005, 32'h0000_0005, 1'b0);
        run_lit("neg_min",     2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_lit("abs_min",     2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_lit("smag_min",    2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // Backpressure in DONE with an overflowing result held.
        outReady = 1'b0;
        issue(2'b11, 32'h8000_0000);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1; mode = 2'b01; dIn = $urandom;
            @(negedge clk);
            chk("bp_outValid", {31'b0, outValid}, 32'd1);
            chk("bp_inReady", {31'b0, inReady}, 32'd0);
            chk("bp_dOut", dOut, 32'h8000_0000);
            chk("bp_ovf", {31'b0, ovf}, 32'd1);
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        chk("bp_rel_outValid", {31'b0, outValid}, 32'd0);
        chk("bp_rel_inReady", {31'b0, inReady}, 32'd1);
        chk("bp_rel_ovf", {31'b0, ovf}, 32'd0);

        // Asynchronous reset after chunk 2 has been written.
        issue(2'b01, 32'h0000_0123);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("midrst_outValid", {31'b0, outValid}, 32'd0);
        chk("midrst_inReady", {31'b0, inReady}, 32'd1);
        chk("midrst_dOut", dOut, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        run_lit("neg_7_after_rst", 2'b01, 32'h0000_0007, 32'hFFFF_FFF9, 1'b0);

        // Single-chunk instance.
        v16 = 1'b1; m16 = 2'b01; d16 = 16'h0001;
        @(negedge clk);
        v16 = 1'b0; d16 = 16'h5555;
        chk("w16_run_valid", {31'b0, ov16}, 32'd0);
        @(negedge clk);
        chk("w16_valid", {31'b0, ov16}, 32'd1);
        chk("w16_neg1", {16'b0, q16}, 32'h0000_FFFF);
        chk("w16_neg1_ovf", {31'b0, ovf16}, 32'd0);
        @(negedge clk);
        v16 = 1'b1; m16 = 2'b10; d16 = 16'h8000;
        @(negedge clk);
        v16 = 1'b0;
        @(negedge clk);
        chk("w16_abs_min", {16'b0, q16}, 32'h0000_8000);
        chk("w16_abs_min_ovf", {31'b0, ovf16}, 32'd1);
        @(negedge clk);

        // Random ops with random consumer stalls, checked by the model.
        n0 = n_done;
        rand_bp = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       d = 32'h8000_0000;
                1:       d = 32'h0000_0000;
                2:       d = 32'hFFFF_FFFF;
                3:       d = 32'h0000_0001;
                default: d = $urandom;
            endcase
            issue(m, d);
        end
        rand_bp = 1'b0;
        @(negedge clk);
        outReady = 1'b1;
        k = 0;
        while (expq.size() != 0 && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        chk("rand_drain", 32'(expq.size()), 32'd0);
        chk("rand_count", 32'(n_done - n0), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
